dmem_responder: RTL and testbench

Data-memory responder for the pipelined core's MEM stage. It answers the data-side requests produced by instruction decode (DREQ active-low request, DRW 1 = write / 0 = read). It holds a word-addressed on-chip memory and inserts a programmable number of wait states. It drives a stall back to the pipeline until each access completes.

---
 rtl/dmem_if.sv | 25 ++
 rtl/dmem_responder.sv | 149 ++++++++++++++
 tb/tb_dmem_responder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Data-side request/response bundle between the pipeline's MEM stage (master)
// and the data-memory responder (slave).
interface dmem_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic              dreq;
   logic              drw;
   logic [ADDR_W+1:0] daddr;
   logic [DATA_W-1:0] dwdata;
   logic [DATA_W-1:0] drdata;
   logic              dack;
   logic              derr;
   logic              dstall;

   modport master (
      output dreq, drw, daddr, dwdata,
      input  drdata, dack, derr, dstall
   );

   modport slave (
      input  dreq, drw, daddr, dwdata,
      output drdata, dack, derr, dstall
   );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory for the MEM stage with programmable wait states,
// a one-cycle completion strobe and a combinational pipeline stall.
module dmem_responder #(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 32,
   parameter int LATENCY = 2
) (
   input  logic   clk,
   input  logic   rst,
   dmem_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam bit         ZERO_LAT = (LATENCY == 0);
   localparam logic [3:0] CNT_INIT = ZERO_LAT ? 4'd0 : 4'(LATENCY - 1);

   state_t            state_r;
   state_t            state_next_s;
   logic [3:0]        cnt_r;
   logic              req_rw_r;
   logic [ADDR_W+1:0] req_addr_r;
   logic [DATA_W-1:0] req_wdata_r;
   logic [DATA_W-1:0] drdata_r;
   logic              dack_r;
   logic              derr_r;
   logic              dstall_s;
   logic              accept_s;
   logic              eff_rw_s;
   logic [ADDR_W+1:0] eff_addr_s;
   logic              misalign_s;
   logic [ADDR_W-1:0] eff_word_s;

   logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

   assign accept_s   = (state_r == IDLE) && !bus.dreq;
   assign misalign_s = (eff_addr_s[1:0] != 2'b00);
   assign eff_word_s = eff_addr_s[ADDR_W+1:2];

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (!bus.dreq) begin
               state_next_s = ZERO_LAT ? RESP : BUSY;
            end else begin
               state_next_s = IDLE;
            end
         end
         BUSY: begin
            if (cnt_r == 4'd0) begin
               state_next_s = RESP;
            end else begin
               state_next_s = BUSY;
            end
         end
         RESP:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // stall output: held while a request is being accepted or waited on
   always_comb begin
      dstall_s = 1'b0;
      if (rst) begin
         dstall_s = 1'b0;
      end else begin
         case (state_r)
            IDLE:    dstall_s = !bus.dreq;
            BUSY:    dstall_s = 1'b1;
            default: dstall_s = 1'b0;
         endcase
      end
   end

   // with zero latency the response is formed from the live inputs at acceptance
   always_comb begin
      if (accept_s) begin
         eff_rw_s   = bus.drw;
         eff_addr_s = bus.daddr;
      end else begin
         eff_rw_s   = req_rw_r;
         eff_addr_s = req_addr_r;
      end
   end

   // request capture and wait-state counter
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r       <= 4'd0;
         req_rw_r    <= 1'b0;
         req_addr_r  <= '0;
         req_wdata_r <= '0;
      end else if (accept_s) begin
         cnt_r       <= CNT_INIT;
         req_rw_r    <= bus.drw;
         req_addr_r  <= bus.daddr;
         req_wdata_r <= bus.dwdata;
      end else if ((state_r == BUSY) && (cnt_r != 4'd0)) begin
         cnt_r <= cnt_r - 4'd1;
      end
   end

   // response registers, loaded on the edge that enters RESP
   always_ff @(posedge clk) begin
      if (rst) begin
         dack_r   <= 1'b0;
         derr_r   <= 1'b0;
         drdata_r <= '0;
      end else if (state_next_s == RESP) begin
         dack_r <= 1'b1;
         derr_r <= misalign_s;
         if (!eff_rw_s && !misalign_s) begin
            drdata_r <= mem[eff_word_s];
         end else begin
            drdata_r <= '0;
         end
      end else begin
         dack_r   <= 1'b0;
         derr_r   <= 1'b0;
         drdata_r <= '0;
      end
   end

   // store commit at the RESP edge; contents survive reset
   always_ff @(posedge clk) begin
      if (!rst && (state_r == RESP) && req_rw_r && (req_addr_r[1:0] == 2'b00)) begin
         mem[req_addr_r[ADDR_W+1:2]] <= req_wdata_r;
      end
   end

   assign bus.drdata = drdata_r;
   assign bus.dack   = dack_r;
   assign bus.derr   = derr_r;
   assign bus.dstall = dstall_s;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=2 and one at LATENCY=0.
module tb_dmem_responder;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   dmem_if #(.ADDR_W(10), .DATA_W(32)) ia ();
   dmem_if #(.ADDR_W(10), .DATA_W(32)) ib ();

   dmem_responder #(.ADDR_W(10), .DATA_W(32), .LATENCY(2)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ia)
   );

   dmem_responder #(.ADDR_W(10), .DATA_W(32), .LATENCY(0)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ib)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic req, input logic rw,
                        input logic [11:0] addr, input logic [31:0] wd);
      if (sel) begin
         ib.dreq = req; ib.drw = rw; ib.daddr = addr; ib.dwdata = wd;
      end else begin
         ia.dreq = req; ia.drw = rw; ia.daddr = addr; ia.dwdata = wd;
      end
   endtask

   function automatic logic get_stall(input bit sel);
      return sel ? ib.dstall : ia.dstall;
   endfunction

   function automatic logic get_ack(input bit sel);
      return sel ? ib.dack : ia.dack;
   endfunction

   function automatic logic get_err(input bit sel);
      return sel ? ib.derr : ia.derr;
   endfunction

   function automatic logic [31:0] get_data(input bit sel);
      return sel ? ib.drdata : ia.drdata;
   endfunction

   // Called at a negedge; counts stall cycles up to the DACK cycle and leaves
   // DREQ low there so the caller can idle or chain the next access.
   task automatic access(input bit sel, input logic rw, input logic [11:0] addr,
                         input logic [31:0] wd, input int exp_stall,
                         input logic [31:0] exp_data, input logic exp_err,
                         input string tag);
      int stalls;
      int n;
      drive(sel, 1'b0, rw, addr, wd);
      #1;
      stalls = int'(get_stall(sel));
      n = 0;
      @(negedge clk);
      while (!get_ack(sel) && n < 40) begin
         stalls += int'(get_stall(sel));
         n++;
         @(negedge clk);
      end
      chk({tag, "_stalls"}, 32'(stalls), 32'(exp_stall));
      chk({tag, "_ack"},    32'(get_ack(sel)),   32'd1);
      chk({tag, "_nostall"},32'(get_stall(sel)), 32'd0);
      chk({tag, "_err"},    32'(get_err(sel)),   32'(exp_err));
      chk({tag, "_data"},   get_data(sel),       exp_data);
   endtask

   task automatic idle(input bit sel, input string tag);
      drive(sel, 1'b1, 1'b0, 12'h000, 32'h0000_0000);
      @(negedge clk);
      chk({tag, "_ack_low"},   32'(get_ack(sel)),   32'd0);
      chk({tag, "_stall_low"}, 32'(get_stall(sel)), 32'd0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      drive(1'b0, 1'b0, 1'b1, 12'h040, 32'hDEAD_BEEF);
      drive(1'b1, 1'b0, 1'b0, 12'h000, 32'h0000_0000);

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_stall_a", 32'(ia.dstall), 32'd0);
         chk("rst_ack_a",   32'(ia.dack),   32'd0);
         chk("rst_data_a",  ia.drdata,      32'h0000_0000);
         chk("rst_stall_b", 32'(ib.dstall), 32'd0);
      end
      rst = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 12'h000, 32'h0000_0000);

      // store/load at LATENCY=2, first request accepted right after reset
      access(1'b0, 1'b1, 12'h040, 32'hDEAD_BEEF, 3, 32'h0000_0000, 1'b0, "st40");
      idle(1'b0, "st40");
      access(1'b0, 1'b0, 12'h040, 32'h0000_0000, 3, 32'hDEAD_BEEF, 1'b0, "ld40");
      idle(1'b0, "ld40");

      // misaligned store must not touch memory
      access(1'b0, 1'b1, 12'h042, 32'hFFFF_FFFF, 3, 32'h0000_0000, 1'b1, "st42");
      idle(1'b0, "st42");
      access(1'b0, 1'b0, 12'h040, 32'h0000_0000, 3, 32'hDEAD_BEEF, 1'b0, "ld40b");
      idle(1'b0, "ld40b");

      // back-to-back with DREQ held low through the store's DACK cycle
      access(1'b0, 1'b1, 12'h010, 32'hA5A5_A5A5, 3, 32'h0000_0000, 1'b0, "b2b_st");
      access(1'b0, 1'b0, 12'h010, 32'h0000_0000, 3, 32'hA5A5_A5A5, 1'b0, "b2b_ld");
      idle(1'b0, "b2b_ld");

      // reset during BUSY drops the pending store
      access(1'b0, 1'b1, 12'h020, 32'h2222_2222, 3, 32'h0000_0000, 1'b0, "st20");
      idle(1'b0, "st20");
      drive(1'b0, 1'b0, 1'b1, 12'h020, 32'h1111_1111);
      @(negedge clk);
      chk("mid_busy_stall", 32'(ia.dstall), 32'd1);
      rst = 1'b1;
      drive(1'b0, 1'b1, 1'b0, 12'h000, 32'h0000_0000);
      #1;
      chk("mid_rst_stall", 32'(ia.dstall), 32'd0);
      @(negedge clk);
      chk("mid_rst_ack", 32'(ia.dack), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ack",   32'(ia.dack),   32'd0);
      chk("post_rst_stall", 32'(ia.dstall), 32'd0);
      access(1'b0, 1'b0, 12'h020, 32'h0000_0000, 3, 32'h2222_2222, 1'b0, "ld20");
      idle(1'b0, "ld20");

      // zero-latency instance
      access(1'b1, 1'b1, 12'h008, 32'h1234_5678, 1, 32'h0000_0000, 1'b0, "b_st8");
      idle(1'b1, "b_st8");
      access(1'b1, 1'b0, 12'h008, 32'h0000_0000, 1, 32'h1234_5678, 1'b0, "b_ld8");
      idle(1'b1, "b_ld8");
      access(1'b1, 1'b0, 12'h009, 32'h0000_0000, 1, 32'h0000_0000, 1'b1, "b_ld9");
      idle(1'b1, "b_ld9");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
